// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared encodings for the game FSMD and its downstream consumers.
//
// Contents:
//   RES_*        2-bit result code. Used for the round result `m`, the game
//                result {pa1,pa0} and the tournament `champion`.
//   sb_state_t   match_scoreboard state codes (visible on `fsm_state`).
//   leader()     champion code for a finished tournament decided on count.
// -----------------------------------------------------------------------------
package game_pkg;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_PLAY       = 2'b01,
    ST_GAME_OVER  = 2'b10,
    ST_TOURN_OVER = 2'b11
  } sb_state_t;

  // Result of a tournament that ran out of games: the player with more won
  // games, or a tie when the counts are equal.
  function automatic logic [1:0] leader(input logic [2:0] wins_p1,
                                        input logic [2:0] wins_p2);
    if (wins_p1 > wins_p2)      return RES_P1;
    else if (wins_p2 > wins_p1) return RES_P2;
    else                        return RES_DRAW;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//
// Parameters:
//   W      counter width in bits
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset, clears the count
//   clr    synchronous clear, wins over inc
//   inc    count up by one unless already saturated
//   cnt    current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // NOTE: state registers are written only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/match_scoreboard.sv
// -----------------------------------------------------------------------------
// match_scoreboard
// Consumes the game FSMD's per-round result and end-of-game flags, tallies the
// rounds of the current game, counts games over a tournament, and names the
// tournament champion.
//
// Parameters:
//   GAMES_TO_WIN  won games that end the tournament (1..7)
//   MAX_GAMES     games played, draws included, that force the end (1..7)
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   i             new-game start (also initialises the FSMD)
//   new_tourn     clear the tournament and return to IDLE
//   m             round result: 00 none, 01 P1, 10 P2, 11 draw
//   pa1, pa0      game result {pa1,pa0}: 00 running, 01 P1, 10 P2, 11 draw
//   cnt_p1        rounds won by P1 in the current game (saturating)
//   cnt_p2        rounds won by P2 in the current game (saturating)
//   cnt_draw      drawn rounds in the current game (saturating)
//   games_p1      games won by P1 in the tournament
//   games_p2      games won by P2 in the tournament
//   games_played  games finished, draws included
//   game_done     one-cycle pulse the cycle after a game ends
//   last_game     result of the last finished game
//   tourn_over    high while the tournament is over
//   champion      01 P1, 10 P2, 11 tie, 00 undecided
//   fsm_state     current state code
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module match_scoreboard
  import game_pkg::*;
#(
  parameter int GAMES_TO_WIN = 3,
  parameter int MAX_GAMES    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i,
  input  logic       new_tourn,
  input  logic [1:0] m,
  input  logic       pa1,
  input  logic       pa0,
  output logic [3:0] cnt_p1,
  output logic [3:0] cnt_p2,
  output logic [3:0] cnt_draw,
  output logic [2:0] games_p1,
  output logic [2:0] games_p2,
  output logic [2:0] games_played,
  output logic       game_done,
  output logic [1:0] last_game,
  output logic       tourn_over,
  output logic [1:0] champion,
  output logic [1:0] fsm_state
);

  localparam logic [2:0] WIN_LIMIT  = 3'(GAMES_TO_WIN);
  localparam logic [2:0] GAME_LIMIT = 3'(MAX_GAMES);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  sb_state_t  state_q;
  logic [1:0] pa_prev_q;
  logic [2:0] games_p1_q;
  logic [2:0] games_p2_q;
  logic [2:0] games_played_q;
  logic [1:0] last_game_q;
  logic [1:0] champion_q;
  logic       game_done_q;

  logic [1:0] pa;
  assign pa = {pa1, pa0};

  // ---------------------------------------------------------------------------
  // Round tallies
  // ---------------------------------------------------------------------------
  // Rounds are only scored in PLAY and only when nothing of higher priority
  // (tournament clear, game restart) claims the cycle.
  logic round_en;
  logic clr_rounds;

  assign round_en   = (state_q == ST_PLAY) && !new_tourn && !i;
  // `i` clears the round tallies from every state except TOURN_OVER, where
  // the final game stays on display until a new tournament.
  assign clr_rounds = new_tourn || (i && (state_q != ST_TOURN_OVER));

  sat_counter #(.W(4)) u_cnt_p1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_rounds),
    .inc   (round_en && (m == RES_P1)),
    .cnt   (cnt_p1)
  );

  sat_counter #(.W(4)) u_cnt_p2 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_rounds),
    .inc   (round_en && (m == RES_P2)),
    .cnt   (cnt_p2)
  );

  sat_counter #(.W(4)) u_cnt_draw (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_rounds),
    .inc   (round_en && (m == RES_DRAW)),
    .cnt   (cnt_draw)
  );

  // ---------------------------------------------------------------------------
  // Game end detection and tournament decision
  // ---------------------------------------------------------------------------
  // A game ends on the rising edge of a non-zero {pa1,pa0}. Comparing with the
  // previous cycle keeps a held result from being counted again.
  logic game_end;
  assign game_end = round_en && (pa != RES_NONE) && (pa_prev_q == RES_NONE);

  logic [2:0] games_p1_d;
  logic [2:0] games_p2_d;
  logic [2:0] games_played_d;
  sb_state_t  end_state_d;
  logic [1:0] champion_d;

  // NOTE: every signal assigned in this block gets a value on every path
  // (defaults first), so it synthesises to gates and never to a latch.
  always_comb begin
    games_p1_d     = games_p1_q + 3'(pa == RES_P1);
    games_p2_d     = games_p2_q + 3'(pa == RES_P2);
    games_played_d = games_played_q + 3'd1;
    end_state_d    = ST_GAME_OVER;
    champion_d     = champion_q;

    // Decided on the counts as they will stand after this game.
    if (games_p1_d == WIN_LIMIT) begin
      end_state_d = ST_TOURN_OVER;
      champion_d  = RES_P1;
    end else if (games_p2_d == WIN_LIMIT) begin
      end_state_d = ST_TOURN_OVER;
      champion_d  = RES_P2;
    end else if (games_played_d == GAME_LIMIT) begin
      end_state_d = ST_TOURN_OVER;
      champion_d  = leader(games_p1_d, games_p2_d);
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pa_prev_q      <= RES_NONE;
      games_p1_q     <= '0;
      games_p2_q     <= '0;
      games_played_q <= '0;
      last_game_q    <= RES_NONE;
      champion_q     <= RES_NONE;
      game_done_q    <= 1'b0;
    end else begin
      // Edge detector history runs in every state so a result already
      // present when PLAY is entered is seen as held, not as a new edge.
      pa_prev_q   <= pa;
      game_done_q <= 1'b0;

      if (new_tourn) begin
        state_q        <= ST_IDLE;
        games_p1_q     <= '0;
        games_p2_q     <= '0;
        games_played_q <= '0;
        last_game_q    <= RES_NONE;
        champion_q     <= RES_NONE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (i) state_q <= ST_PLAY;
          end

          ST_PLAY: begin
            // `i` here restarts the game in place; game_end is already
            // masked by it, so only the tally clear happens.
            if (game_end) begin
              game_done_q    <= 1'b1;
              last_game_q    <= pa;
              games_p1_q     <= games_p1_d;
              games_p2_q     <= games_p2_d;
              games_played_q <= games_played_d;
              champion_q     <= champion_d;
              state_q        <= end_state_d;
            end
          end

          ST_GAME_OVER: begin
            if (i) state_q <= ST_PLAY;
          end

          ST_TOURN_OVER: begin
            // Terminal until new_tourn or reset.
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign games_p1     = games_p1_q;
  assign games_p2     = games_p2_q;
  assign games_played = games_played_q;
  assign game_done    = game_done_q;
  assign last_game    = last_game_q;
  assign champion     = champion_q;
  assign fsm_state    = state_q;
  assign tourn_over   = (state_q == ST_TOURN_OVER);

endmodule

// File: tb/tb_match_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_match_scoreboard
// Self-checking bench for match_scoreboard with default parameters (3 / 5).
// A behavioural model follows the scoreboard rules on every rising edge; a
// compare process checks every output against it on each falling edge.
// Directed scenarios add hand-computed literal expectations, then a
// randomized phase exercises priorities and edge cases.
// -----------------------------------------------------------------------------
module tb_match_scoreboard;

  localparam int G_WIN = 3;
  localparam int G_MAX = 5;

  localparam int S_IDLE = 0;
  localparam int S_PLAY = 1;
  localparam int S_GO   = 2;
  localparam int S_TO   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i;
  logic       new_tourn;
  logic [1:0] m;
  logic       pa1;
  logic       pa0;
  logic [3:0] cnt_p1;
  logic [3:0] cnt_p2;
  logic [3:0] cnt_draw;
  logic [2:0] games_p1;
  logic [2:0] games_p2;
  logic [2:0] games_played;
  logic       game_done;
  logic [1:0] last_game;
  logic       tourn_over;
  logic [1:0] champion;
  logic [1:0] fsm_state;

  always #5 clk = ~clk;

  match_scoreboard #(
    .GAMES_TO_WIN (G_WIN),
    .MAX_GAMES    (G_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i            (i),
    .new_tourn    (new_tourn),
    .m            (m),
    .pa1          (pa1),
    .pa0          (pa0),
    .cnt_p1       (cnt_p1),
    .cnt_p2       (cnt_p2),
    .cnt_draw     (cnt_draw),
    .games_p1     (games_p1),
    .games_p2     (games_p2),
    .games_played (games_played),
    .game_done    (game_done),
    .last_game    (last_game),
    .tourn_over   (tourn_over),
    .champion     (champion),
    .fsm_state    (fsm_state)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int md_state, md_c1, md_c2, md_cd, md_g1, md_g2, md_gp, md_last, md_champ;
  int md_done, md_prev;

  function automatic int bump15(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  always @(posedge clk) begin
    int s, c1, c2, cd, g1, g2, gp, lg, ch, dn, res;
    s = md_state; c1 = md_c1; c2 = md_c2; cd = md_cd;
    g1 = md_g1; g2 = md_g2; gp = md_gp; lg = md_last; ch = md_champ;
    dn = 0;
    res = int'({pa1, pa0});

    if (!rst_n) begin
      s = S_IDLE; c1 = 0; c2 = 0; cd = 0; g1 = 0; g2 = 0; gp = 0; lg = 0; ch = 0;
      res = 0;
    end else if (new_tourn) begin
      s = S_IDLE; c1 = 0; c2 = 0; cd = 0; g1 = 0; g2 = 0; gp = 0; lg = 0; ch = 0;
    end else if (i && s != S_TO) begin
      s = S_PLAY; c1 = 0; c2 = 0; cd = 0;
    end else if (s == S_PLAY) begin
      if (m == 2'd1) c1 = bump15(c1);
      if (m == 2'd2) c2 = bump15(c2);
      if (m == 2'd3) cd = bump15(cd);
      if (res != 0 && md_prev == 0) begin
        dn = 1;
        lg = res;
        gp++;
        if (res == 1) g1++;
        if (res == 2) g2++;
        s = S_TO;
        if (g1 == G_WIN)       ch = 1;
        else if (g2 == G_WIN)  ch = 2;
        else if (gp == G_MAX)  ch = (g1 > g2) ? 1 : (g2 > g1) ? 2 : 3;
        else                   s = S_GO;
      end
    end

    md_state <= s; md_c1 <= c1; md_c2 <= c2; md_cd <= cd;
    md_g1 <= g1; md_g2 <= g2; md_gp <= gp; md_last <= lg; md_champ <= ch;
    md_done <= dn; md_prev <= res;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("fsm_state",    int'(fsm_state),    md_state);
      check("cnt_p1",       int'(cnt_p1),       md_c1);
      check("cnt_p2",       int'(cnt_p2),       md_c2);
      check("cnt_draw",     int'(cnt_draw),     md_cd);
      check("games_p1",     int'(games_p1),     md_g1);
      check("games_p2",     int'(games_p2),     md_g2);
      check("games_played", int'(games_played), md_gp);
      check("game_done",    int'(game_done),    md_done);
      check("last_game",    int'(last_game),    md_last);
      check("tourn_over",   int'(tourn_over),   int'(md_state == S_TO));
      check("champion",     int'(champion),     md_champ);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc(input bit r, input bit ii, input bit nt,
                     input logic [1:0] mm, input logic [1:0] pp);
    rst_n = r; i = ii; new_tourn = nt; m = mm; {pa1, pa0} = pp;
    @(posedge clk);
    #1;
  endtask

  // One complete game: start pulse, a few rounds, result edge, release.
  task automatic play_game(input logic [1:0] res);
    cyc(1, 1, 0, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 2'($urandom_range(0, 3)), 2'b00);
    cyc(1, 0, 0, 2'b00, res);
    cyc(1, 0, 0, 2'b00, 2'b00);
  endtask

  task automatic expect_cleared(input string tag);
    check({tag, "_state"}, int'(fsm_state),    S_IDLE);
    check({tag, "_c1"},    int'(cnt_p1),       0);
    check({tag, "_c2"},    int'(cnt_p2),       0);
    check({tag, "_cd"},    int'(cnt_draw),     0);
    check({tag, "_gp"},    int'(games_played), 0);
    check({tag, "_g1"},    int'(games_p1),     0);
    check({tag, "_champ"}, int'(champion),     0);
    check({tag, "_last"},  int'(last_game),    0);
    check({tag, "_to"},    int'(tourn_over),   0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0] pa_r;
    rst_n = 1'b0; i = 1'b0; new_tourn = 1'b0; m = 2'b00; {pa1, pa0} = 2'b00;

    cyc(0, 0, 0, 2'b00, 2'b00);
    cyc(0, 0, 0, 2'b00, 2'b00);
    chk_en = 1'b1;
    expect_cleared("reset");

    // Start and score a few rounds.
    cyc(1, 1, 0, 2'b00, 2'b00);
    check("start_state", int'(fsm_state), S_PLAY);
    check("start_champ", int'(champion), 0);
    cyc(1, 0, 0, 2'b01, 2'b00);
    cyc(1, 0, 0, 2'b01, 2'b00);
    cyc(1, 0, 0, 2'b11, 2'b00);
    cyc(1, 0, 0, 2'b00, 2'b00);
    cyc(1, 0, 0, 2'b10, 2'b00);
    check("rounds_p1", int'(cnt_p1), 2);
    check("rounds_draw", int'(cnt_draw), 1);
    check("rounds_p2", int'(cnt_p2), 1);

    // P1 wins, result held three cycles: one pulse, one game counted.
    cyc(1, 0, 0, 2'b00, 2'b01);
    check("g1_done_pulse", int'(game_done), 1);
    cyc(1, 0, 0, 2'b00, 2'b01);
    check("g1_done_low", int'(game_done), 0);
    cyc(1, 0, 0, 2'b00, 2'b01);
    check("g1_games_p1", int'(games_p1), 1);
    check("g1_played", int'(games_played), 1);
    check("g1_state", int'(fsm_state), S_GO);
    check("g1_hold_p1", int'(cnt_p1), 2);
    cyc(1, 0, 0, 2'b00, 2'b00);

    // Saturation of a round counter.
    cyc(1, 1, 0, 2'b00, 2'b00);
    for (int k = 0; k < 16; k++) cyc(1, 0, 0, 2'b10, 2'b00);
    check("sat_p2", int'(cnt_p2), 15);
    cyc(1, 0, 0, 2'b00, 2'b10);
    cyc(1, 0, 0, 2'b00, 2'b00);

    // Three P1 games end the tournament.
    cyc(1, 0, 1, 2'b00, 2'b00);
    expect_cleared("nt1");
    for (int k = 0; k < 3; k++) play_game(2'b01);
    check("win3_to", int'(tourn_over), 1);
    check("win3_champ", int'(champion), 1);
    check("win3_g1", int'(games_p1), 3);
    cyc(1, 1, 0, 2'b01, 2'b00);
    check("win3_i_ignored", int'(fsm_state), S_TO);
    cyc(1, 0, 1, 2'b00, 2'b00);
    expect_cleared("nt2");

    // Game limit reached with equal wins: tie.
    play_game(2'b01);
    play_game(2'b10);
    play_game(2'b11);
    play_game(2'b11);
    check("max_pre_state", int'(fsm_state), S_GO);
    play_game(2'b11);
    check("max_state", int'(fsm_state), S_TO);
    check("max_champ", int'(champion), 3);
    check("max_played", int'(games_played), 5);

    // Round and game end in the same cycle, result then held.
    cyc(1, 0, 1, 2'b00, 2'b00);
    cyc(1, 1, 0, 2'b00, 2'b00);
    cyc(1, 0, 0, 2'b10, 2'b10);
    check("same_c2", int'(cnt_p2), 1);
    check("same_g2", int'(games_p2), 1);
    cyc(1, 0, 0, 2'b00, 2'b10);
    check("same_once", int'(games_played), 1);
    cyc(1, 0, 0, 2'b00, 2'b00);

    // Reset in the middle of a game.
    cyc(1, 1, 0, 2'b00, 2'b00);
    cyc(1, 0, 0, 2'b01, 2'b00);
    cyc(1, 0, 0, 2'b11, 2'b00);
    cyc(0, 0, 0, 2'b01, 2'b00);
    expect_cleared("midrst");
    check("midrst_g2", int'(games_p2), 0);

    // Randomized phase: model comparison on every cycle.
    pa_r = 2'b00;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0)
        pa_r = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 149) == 0),
          2'($urandom_range(0, 3)),
          pa_r);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/match_scoreboard.md
Name: match_scoreboard

Overview:
- Downstream consumer of the game FSMD's per-round result `m[1:0]` and end-of-game flags `pa1`/`pa0`.
- Tallies rounds (manche) within the current game and tracks a multi-game tournament.
- Declares the tournament champion and produces one-cycle event pulses for display/logging logic.
- Sits between the game FSMD and the display/output layer; samples the FSMD outputs on the same `clk`.

Parameters:
- GAMES_TO_WIN, 3: number of won games that ends the tournament (1..7).
- MAX_GAMES, 5: maximum games played (draws included) before forced tournament end (1..7, >= GAMES_TO_WIN).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- i  in  1  new-game start (same signal that initialises the FSMD)
- new_tourn  in  1  clear tournament, return to IDLE
- m  in  2  round result from FSMD: 00 invalid, 01 P1 wins, 10 P2 wins, 11 draw
- pa1  in  1  game result bit 1 from FSMD
- pa0  in  1  game result bit 0 from FSMD ({pa1,pa0}: 00 running, 01 P1, 10 P2, 11 draw)
- cnt_p1  out  4  rounds won by P1 in current game
- cnt_p2  out  4  rounds won by P2 in current game
- cnt_draw  out  4  drawn rounds in current game
- games_p1  out  3  games won by P1 in tournament
- games_p2  out  3  games won by P2 in tournament
- games_played  out  3  games finished, draws included
- game_done  out  1  one-cycle pulse at game end
- last_game  out  2  result of last finished game, encoded as {pa1,pa0}
- tourn_over  out  1  level, high in TOURN_OVER
- champion  out  2  01 P1, 10 P2, 11 tie, 00 undecided
- fsm_state  out  2  current state code

Behaviour:
- Reset: `rst_n`=0 at a rising edge forces
  - state IDLE;
  - all counters, `last_game`, `champion` and `pa_prev` to 0;
  - `game_done` and `tourn_over` to 0.
- Reset mid-game discards all progress.
- Priority, highest first: `rst_n`, then `new_tourn` (any state → IDLE, all outputs cleared as at reset), then `i`, then `m`/`pa` processing.
- `pa_prev` register:
  - holds {pa1,pa0} from the previous cycle and updates every cycle;
  - game end event = state PLAY and {pa1,pa0}!=00 and `pa_prev`==00.
- State encoding: IDLE=00, PLAY=01, GAME_OVER=10, TOURN_OVER=11.
- IDLE:
  - `m` and `pa` are ignored.
  - `i`=1 → PLAY next cycle; `cnt_p1`/`cnt_p2`/`cnt_draw` cleared.
- PLAY:
  - Each cycle with `m`!=00 increments the matching round counter. Counters saturate at 15, no wrap.
  - `i`=1 aborts the current game: round counters cleared, stay in PLAY, no game counted, that cycle's `m` ignored.
  - Game end event:
    - `game_done`=1 for exactly the next cycle; `last_game`<={pa1,pa0};
    - `games_played`+1; `games_p1`+1 if 01; `games_p2`+1 if 10; neither if 11.
  - A round with `m`!=00 in the same cycle as the game end event is counted.
  - After the updated game counts are applied, evaluate in this order:
    - `games_p1`==GAMES_TO_WIN → TOURN_OVER, `champion`=01;
    - else `games_p2`==GAMES_TO_WIN → TOURN_OVER, `champion`=10;
    - else `games_played`==MAX_GAMES → TOURN_OVER, `champion` = the leader, or 11 if equal;
    - otherwise → GAME_OVER.
- GAME_OVER:
  - Round counters hold their final values for display; `m` ignored.
  - `i`=1 → PLAY, round counters cleared.
- TOURN_OVER:
  - `tourn_over`=1; all counters and `champion` hold.
  - `i` and `m` ignored; only `new_tourn` or reset leaves.
- `game_done` latency: game end event at rising edge N → `game_done` high during cycle N+1.
- Only one game is counted per PLAY entry: `pa` remaining non-zero does not retrigger, because `pa_prev` is non-zero.
- Game counters are 3 bits; the parameter range guarantees no overflow.
- Outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Shared package `game_pkg`:
  - result encodings RES_NONE=00, RES_P1=01, RES_P2=10, RES_DRAW=11, used for `m`, {pa1,pa0}, `champion`;
  - state typedef `sb_state_t` with the four codes above.
- One sub-module `sat_counter` (parameterised width, `clr`, `inc`, saturating). It is instantiated for `cnt_p1`, `cnt_p2` and `cnt_draw`.

Test Plan:
- Reset with `rst_n`=0 for 2 cycles, then `i`=1 pulse → `fsm_state`=01, all counters 0, `champion`=00, `tourn_over`=0.
- In PLAY, drive `m`=01,01,11,00,10 on consecutive cycles → `cnt_p1`=2, `cnt_draw`=1, `cnt_p2`=1. Then {pa1,pa0}=01 held 3 cycles → `game_done` high exactly 1 cycle, `games_p1`=1, `games_played`=1, state GAME_OVER.
- Drive 16 cycles of `m`=10 → `cnt_p2` saturates at 15.
- Play 3 games won by P1 with GAMES_TO_WIN=3, each game opened by an `i` pulse → after third game: `tourn_over`=1, `champion`=01, `games_p1`=3. A subsequent `i` leaves state at 11; `new_tourn` → IDLE with all outputs cleared.
- With MAX_GAMES=5, play results 01,10,11,11,11 → after fifth game: TOURN_OVER, `champion`=11, `games_played`=5.
- Same cycle `m`=10 and {pa1,pa0} rising to 10 → `cnt_p2` increments and game counted once. Separately, assert `rst_n`=0 mid-PLAY → next cycle all outputs 0 and state IDLE.
